// File: rtl/irq_nest_ctrl_if.sv
// Bundle between the WB stage and the nested interrupt controller: request lines,
// mask/IE/ERET controls and resume PC in; PC redirects and status out.
interface irq_nest_ctrl_if #(
   parameter int NUM_IRQ    = 4,
   parameter int NEST_DEPTH = 4,
   parameter int PC_W       = 32
);
   localparam int ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int LVL_W = $clog2(NUM_IRQ + 1);
   localparam int DEP_W = $clog2(NEST_DEPTH + 1);

   logic [NUM_IRQ-1:0] irq;
   logic               mask_we;
   logic [NUM_IRQ-1:0] mask_din;
   logic               global_ie;
   logic               eret;
   logic [PC_W-1:0]    resume_pc;

   logic               int_req;
   logic [PC_W-1:0]    int_pc;
   logic [ID_W-1:0]    int_id;
   logic               eret_valid;
   logic [PC_W-1:0]    eret_pc;
   logic [NUM_IRQ-1:0] pending;
   logic [LVL_W-1:0]   cur_level;
   logic [DEP_W-1:0]   depth;
   logic               err_underflow;

   modport master (
      output irq, mask_we, mask_din, global_ie, eret, resume_pc,
      input  int_req, int_pc, int_id, eret_valid, eret_pc, pending, cur_level, depth,
             err_underflow
   );

   modport slave (
      input  irq, mask_we, mask_din, global_ie, eret, resume_pc,
      output int_req, int_pc, int_id, eret_valid, eret_pc, pending, cur_level, depth,
             err_underflow
   );
endinterface

// File: rtl/irq_nest_ctrl.sv
// Nested, fixed-priority interrupt controller in WB: latches request edges, picks the
// lowest eligible channel, stacks {EPC, level} on accept and unwinds it on ERET.
module irq_nest_ctrl #(
   parameter int              NUM_IRQ    = 4,
   parameter int              NEST_DEPTH = 4,
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(32'h0000_0578),
   parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(32'h0000_00C8)
) (
   input logic            clk,
   input logic            rst,
   irq_nest_ctrl_if.slave bus
);
   localparam int ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int LVL_W = $clog2(NUM_IRQ + 1);
   localparam int DEP_W = $clog2(NEST_DEPTH + 1);

   function automatic logic [PC_W-1:0] vector_of(input logic [ID_W-1:0] id);
      logic [PC_W-1:0] id_ext;
      id_ext = PC_W'(id);
      return VEC_BASE + id_ext * VEC_STRIDE;
   endfunction

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [LVL_W-1:0]   cur_level_q, cur_level_d;
   logic [DEP_W-1:0]   depth_q, depth_d;
   logic [PC_W-1:0]    stk_pc_q  [NEST_DEPTH];
   logic [LVL_W-1:0]   stk_lvl_q [NEST_DEPTH];
   logic               int_req_q, int_req_d;
   logic [PC_W-1:0]    int_pc_q, int_pc_d;
   logic [ID_W-1:0]    int_id_q, int_id_d;
   logic               eret_valid_q, eret_valid_d;
   logic [PC_W-1:0]    eret_pc_q, eret_pc_d;
   logic               err_q, err_d;

   logic [NUM_IRQ-1:0] edge_w;
   logic [NUM_IRQ-1:0] elig_w;
   logic [NUM_IRQ-1:0] clr_w;
   logic               stack_room;
   logic               do_push;
   logic [ID_W-1:0]    sel_id;
   logic [PC_W-1:0]    top_pc;
   logic [LVL_W-1:0]   top_lvl;

   always_comb begin
      edge_w     = bus.irq & ~irq_q;
      stack_room = (depth_q < DEP_W'(NEST_DEPTH));
      elig_w     = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         elig_w[i] = pending_q[i] & mask_q[i] & bus.global_ie &
                     (LVL_W'(i) < cur_level_q) & stack_room;
      end
   end

   // Scan from the top down so the lowest eligible index wins.
   always_comb begin
      sel_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig_w[i]) sel_id = ID_W'(i);
      end
   end

   always_comb begin
      top_pc  = '0;
      top_lvl = '0;
      for (int k = 0; k < NEST_DEPTH; k++) begin
         if (depth_q == DEP_W'(k + 1)) begin
            top_pc  = stk_pc_q[k];
            top_lvl = stk_lvl_q[k];
         end
      end
   end

   always_comb begin
      do_push      = !bus.eret && (|elig_w);
      clr_w        = do_push ? (NUM_IRQ'(1) << sel_id) : '0;
      // A fresh edge on the channel being accepted re-arms it.
      pending_d    = (pending_q & ~clr_w) | edge_w;
      mask_d       = bus.mask_we ? bus.mask_din : mask_q;
      cur_level_d  = cur_level_q;
      depth_d      = depth_q;
      int_req_d    = 1'b0;
      int_pc_d     = int_pc_q;
      int_id_d     = int_id_q;
      eret_valid_d = 1'b0;
      eret_pc_d    = eret_pc_q;
      err_d        = err_q;
      if (bus.eret) begin
         if (depth_q != '0) begin
            cur_level_d  = top_lvl;
            eret_pc_d    = top_pc;
            eret_valid_d = 1'b1;
            depth_d      = depth_q - DEP_W'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (do_push) begin
         cur_level_d = LVL_W'(sel_id);
         depth_d     = depth_q + DEP_W'(1);
         int_req_d   = 1'b1;
         int_id_d    = sel_id;
         int_pc_d    = vector_of(sel_id);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q        <= '0;
         pending_q    <= '0;
         mask_q       <= '1;
         cur_level_q  <= LVL_W'(NUM_IRQ);
         depth_q      <= '0;
         int_req_q    <= 1'b0;
         int_pc_q     <= '0;
         int_id_q     <= '0;
         eret_valid_q <= 1'b0;
         eret_pc_q    <= '0;
         err_q        <= 1'b0;
         for (int k = 0; k < NEST_DEPTH; k++) begin
            stk_pc_q[k]  <= '0;
            stk_lvl_q[k] <= '0;
         end
      end else begin
         irq_q        <= bus.irq;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         cur_level_q  <= cur_level_d;
         depth_q      <= depth_d;
         int_req_q    <= int_req_d;
         int_pc_q     <= int_pc_d;
         int_id_q     <= int_id_d;
         eret_valid_q <= eret_valid_d;
         eret_pc_q    <= eret_pc_d;
         err_q        <= err_d;
         for (int k = 0; k < NEST_DEPTH; k++) begin
            if (do_push && (depth_q == DEP_W'(k))) begin
               stk_pc_q[k]  <= bus.resume_pc;
               stk_lvl_q[k] <= cur_level_q;
            end
         end
      end
   end

   assign bus.int_req       = int_req_q;
   assign bus.int_pc        = int_pc_q;
   assign bus.int_id        = int_id_q;
   assign bus.eret_valid    = eret_valid_q;
   assign bus.eret_pc       = eret_pc_q;
   assign bus.pending       = pending_q;
   assign bus.cur_level     = cur_level_q;
   assign bus.depth         = depth_q;
   assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Directed bench for irq_nest_ctrl: a depth-4 and a depth-2 instance share stimulus and
// are checked every cycle against a behavioural model, plus literal spot checks.
module tb_irq_nest_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  irq;
   logic        mask_we;
   logic [3:0]  mask_din;
   logic        global_ie;
   logic        eret;
   logic [31:0] resume_pc;
   bit          cmp_en = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   irq_nest_ctrl_if #(.NUM_IRQ(4), .NEST_DEPTH(4), .PC_W(32)) if0 ();
   irq_nest_ctrl_if #(.NUM_IRQ(4), .NEST_DEPTH(2), .PC_W(32)) if1 ();

   assign if0.irq = irq;          assign if1.irq = irq;
   assign if0.mask_we = mask_we;  assign if1.mask_we = mask_we;
   assign if0.mask_din = mask_din; assign if1.mask_din = mask_din;
   assign if0.global_ie = global_ie; assign if1.global_ie = global_ie;
   assign if0.eret = eret;        assign if1.eret = eret;
   assign if0.resume_pc = resume_pc; assign if1.resume_pc = resume_pc;

   irq_nest_ctrl #(.NUM_IRQ(4), .NEST_DEPTH(4), .PC_W(32),
                   .VEC_BASE(32'h578), .VEC_STRIDE(32'hC8))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   irq_nest_ctrl #(.NUM_IRQ(4), .NEST_DEPTH(2), .PC_W(32),
                   .VEC_BASE(32'h578), .VEC_STRIDE(32'hC8))
      dut1 (.clk(clk), .rst(rst), .bus(if1));

   logic        d_req[2], d_ev[2], d_err[2];
   logic [31:0] d_pc[2], d_epc[2], d_id[2], d_pend[2], d_lvl[2], d_dep[2];

   assign d_req[0] = if0.int_req;        assign d_req[1] = if1.int_req;
   assign d_ev[0]  = if0.eret_valid;     assign d_ev[1]  = if1.eret_valid;
   assign d_err[0] = if0.err_underflow;  assign d_err[1] = if1.err_underflow;
   assign d_pc[0]  = if0.int_pc;         assign d_pc[1]  = if1.int_pc;
   assign d_epc[0] = if0.eret_pc;        assign d_epc[1] = if1.eret_pc;
   assign d_id[0]  = 32'(if0.int_id);    assign d_id[1]  = 32'(if1.int_id);
   assign d_pend[0] = 32'(if0.pending);  assign d_pend[1] = 32'(if1.pending);
   assign d_lvl[0] = 32'(if0.cur_level); assign d_lvl[1] = 32'(if1.cur_level);
   assign d_dep[0] = 32'(if0.depth);     assign d_dep[1] = 32'(if1.depth);

   // Behavioural model: explicit stack of (epc, level) frames per instance.
   bit [3:0]    m_irqq[2], m_pend[2], m_mask[2];
   int          m_lvl[2], m_dep[2], m_id[2];
   logic [31:0] m_spc[2][8];
   int          m_slvl[2][8];
   bit          m_req[2], m_ev[2], m_err[2];
   logic [31:0] m_pc[2], m_epc[2];

   task automatic model_reset(input int u);
      m_irqq[u] = '0; m_pend[u] = '0; m_mask[u] = 4'hF;
      m_lvl[u] = 4; m_dep[u] = 0; m_id[u] = 0;
      m_req[u] = 0; m_ev[u] = 0; m_err[u] = 0;
      m_pc[u] = '0; m_epc[u] = '0;
   endtask

   task automatic model_step(input int u, input int nd);
      bit [3:0] rise;
      int pick;
      rise = irq & ~m_irqq[u];
      m_req[u] = 0;
      m_ev[u]  = 0;
      if (eret) begin
         if (m_dep[u] > 0) begin
            m_dep[u] = m_dep[u] - 1;
            m_epc[u] = m_spc[u][m_dep[u]];
            m_lvl[u] = m_slvl[u][m_dep[u]];
            m_ev[u]  = 1;
         end else begin
            m_err[u] = 1;
         end
      end else begin
         pick = -1;
         for (int i = 3; i >= 0; i--)
            if (m_pend[u][i] && m_mask[u][i] && global_ie && i < m_lvl[u] && m_dep[u] < nd)
               pick = i;
         if (pick >= 0) begin
            m_spc[u][m_dep[u]]  = resume_pc;
            m_slvl[u][m_dep[u]] = m_lvl[u];
            m_dep[u]  = m_dep[u] + 1;
            m_lvl[u]  = pick;
            m_pend[u][pick] = 1'b0;
            m_req[u]  = 1;
            m_id[u]   = pick;
            m_pc[u]   = 32'h578 + 32'(pick) * 32'hC8;
         end
      end
      m_pend[u] = m_pend[u] | rise;
      m_irqq[u] = irq;
      if (mask_we) m_mask[u] = mask_din;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset(0);
            model_reset(1);
         end else begin
            model_step(0, 4);
            model_step(1, 2);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_int_req", u), 32'(d_req[u]), 32'(m_req[u]));
            chk($sformatf("u%0d_int_pc", u), d_pc[u], m_pc[u]);
            chk($sformatf("u%0d_int_id", u), d_id[u], 32'(m_id[u]));
            chk($sformatf("u%0d_eret_valid", u), 32'(d_ev[u]), 32'(m_ev[u]));
            chk($sformatf("u%0d_eret_pc", u), d_epc[u], m_epc[u]);
            chk($sformatf("u%0d_pending", u), d_pend[u], 32'(m_pend[u]));
            chk($sformatf("u%0d_cur_level", u), d_lvl[u], 32'(m_lvl[u]));
            chk($sformatf("u%0d_depth", u), d_dep[u], 32'(m_dep[u]));
            chk($sformatf("u%0d_err", u), 32'(d_err[u]), 32'(m_err[u]));
            chk($sformatf("u%0d_excl", u), 32'(d_req[u] & d_ev[u]), 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input int u, input int budget, input string nm);
      int k;
      k = 0;
      do begin
         tick(1);
         k++;
      end while (!d_req[u] && k < budget);
      chk({nm, "_seen"}, 32'(d_req[u]), 32'd1);
   endtask

   task automatic pulse_eret();
      eret = 1'b1;
      tick(1);
      eret = 1'b0;
   endtask

   task automatic quiet(input int u, input int n, input string nm);
      int cnt;
      cnt = 0;
      repeat (n) begin
         tick(1);
         cnt += int'(d_req[u]);
      end
      chk(nm, 32'(cnt), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; irq = '0; mask_we = 1'b0; mask_din = '0;
      global_ie = 1'b1; eret = 1'b0; resume_pc = '0;
      #1 rst = 1'b1;
      cmp_en = 1'b1;
      tick(2);
      chk("rst_int_req", 32'(d_req[0]), 32'd0);
      chk("rst_int_pc", d_pc[0], 32'd0);
      chk("rst_cur_level", d_lvl[0], 32'd4);
      chk("rst_depth", d_dep[0], 32'd0);
      chk("rst_pending", d_pend[0], 32'd0);
      rst = 1'b0;

      // 1: level-held irq[2] gives a single request
      resume_pc = 32'h1000; irq = 4'b0100;
      wait_req(0, 4, "t1");
      chk("t1_id", d_id[0], 32'd2);
      chk("t1_pc", d_pc[0], 32'h708);
      chk("t1_model_pc", m_pc[0], 32'h708);
      chk("t1_depth", d_dep[0], 32'd1);
      quiet(0, 10, "t1_single");
      irq = '0;
      pulse_eret();
      chk("t1_ev", 32'(d_ev[0]), 32'd1);
      chk("t1_epc", d_epc[0], 32'h1000);
      chk("t1_lvl", d_lvl[0], 32'd4);

      // 2: simultaneous irq[1]/irq[3]
      resume_pc = 32'h2000; irq = 4'b1010;
      wait_req(0, 4, "t2a");
      chk("t2a_id", d_id[0], 32'd1);
      chk("t2a_pc", d_pc[0], 32'h640);
      quiet(0, 3, "t2_blocked");
      chk("t2_pend", d_pend[0], 32'b1000);
      irq = '0; resume_pc = 32'h3000;
      pulse_eret();
      chk("t2_epc", d_epc[0], 32'h2000);
      wait_req(0, 3, "t2b");
      chk("t2b_id", d_id[0], 32'd3);
      chk("t2b_pc", d_pc[0], 32'h7D0);
      pulse_eret();
      chk("t2b_epc", d_epc[0], 32'h3000);

      // 3: nesting ch0 over ch2
      resume_pc = 32'h100; irq = 4'b0100;
      wait_req(0, 4, "t3a");
      resume_pc = 32'h200; irq = 4'b0101;
      wait_req(0, 4, "t3b");
      chk("t3b_id", d_id[0], 32'd0);
      chk("t3b_pc", d_pc[0], 32'h578);
      chk("t3b_depth", d_dep[0], 32'd2);
      irq = '0;
      pulse_eret();
      chk("t3_epc1", d_epc[0], 32'h200);
      chk("t3_lvl1", d_lvl[0], 32'd2);
      pulse_eret();
      chk("t3_epc2", d_epc[0], 32'h100);
      chk("t3_lvl2", d_lvl[0], 32'd4);
      chk("t3_model_lvl", 32'(m_lvl[0]), 32'd4);

      // 4: full stack on the depth-2 instance
      resume_pc = 32'h400; irq = 4'b0100;
      wait_req(0, 4, "t4a");
      resume_pc = 32'h500; irq = 4'b0110;
      wait_req(0, 4, "t4b");
      irq = 4'b0111;
      wait_req(0, 4, "t4_u0");
      chk("t4_u1_noreq", 32'(d_req[1]), 32'd0);
      quiet(1, 3, "t4_u1_quiet");
      chk("t4_u1_pend", d_pend[1], 32'b0001);
      chk("t4_u1_depth", d_dep[1], 32'd2);
      chk("t4_u0_depth", d_dep[0], 32'd3);
      pulse_eret();
      chk("t4_u1_epc", d_epc[1], 32'h500);
      wait_req(1, 3, "t4_u1");
      chk("t4_u1_id", d_id[1], 32'd0);
      irq = '0;
      pulse_eret();
      pulse_eret();
      chk("t4_u0_empty", d_dep[0], 32'd0);
      chk("t4_u1_empty", d_dep[1], 32'd0);

      // 5: mask, same-edge re-arm, global IE
      mask_we = 1'b1; mask_din = 4'b1011;
      tick(1);
      mask_we = 1'b0; irq = 4'b0100;
      quiet(0, 4, "t5_masked");
      chk("t5_pend", d_pend[0], 32'b0100);
      mask_we = 1'b1; mask_din = 4'b1111;
      tick(1);
      mask_we = 1'b0;
      tick(1);
      chk("t5_unmask_req", 32'(d_req[0]), 32'd1);
      chk("t5_unmask_id", d_id[0], 32'd2);
      irq = '0;
      pulse_eret();
      mask_we = 1'b1; mask_din = 4'b1101;
      tick(1);
      mask_we = 1'b0; irq = 4'b0010;
      tick(1);
      irq = '0;
      tick(1);
      mask_we = 1'b1; mask_din = 4'b1111;
      tick(1);
      mask_we = 1'b0; irq = 4'b0010;
      tick(1);
      chk("t5_rearm_req", 32'(d_req[0]), 32'd1);
      chk("t5_rearm_pend", d_pend[0], 32'b0010);
      pulse_eret();
      wait_req(0, 3, "t5_rearm2");
      chk("t5_rearm2_id", d_id[0], 32'd1);
      pulse_eret();
      irq = '0; global_ie = 1'b0;
      tick(1);
      irq = 4'b0001;
      quiet(0, 4, "t5_gie_off");
      chk("t5_gie_pend", d_pend[0], 32'b0001);
      global_ie = 1'b1;
      wait_req(0, 3, "t5_gie_on");
      chk("t5_gie_id", d_id[0], 32'd0);
      irq = '0;
      pulse_eret();

      // 6: underflow, then async reset in the middle of a nest
      pulse_eret();
      chk("t6_no_ev", 32'(d_ev[0]), 32'd0);
      chk("t6_err", 32'(d_err[0]), 32'd1);
      resume_pc = 32'h600; irq = 4'b0100;
      wait_req(0, 4, "t6a");
      resume_pc = 32'h700; irq = 4'b0101;
      wait_req(0, 4, "t6b");
      chk("t6_depth", d_dep[0], 32'd2);
      #2 rst = 1'b1;
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("t6_rst_req_u%0d", u), 32'(d_req[u]), 32'd0);
         chk($sformatf("t6_rst_depth_u%0d", u), d_dep[u], 32'd0);
         chk($sformatf("t6_rst_lvl_u%0d", u), d_lvl[u], 32'd4);
         chk($sformatf("t6_rst_err_u%0d", u), 32'(d_err[u]), 32'd0);
         chk($sformatf("t6_rst_pc_u%0d", u), d_pc[u], 32'd0);
         chk($sformatf("t6_rst_epc_u%0d", u), d_epc[u], 32'd0);
         chk($sformatf("t6_rst_pend_u%0d", u), d_pend[u], 32'd0);
      end
      irq = '0;
      tick(1);
      rst = 1'b0;
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
